// File: rtl/uart_rx_cfg_if.sv
// Result bundle of the configurable UART receiver: received word, status pulses and busy.
interface uart_rx_cfg_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              parity_error;
    logic              stop_error;
    logic              break_det;
    logic              busy;

    modport master (output p_data, data_valid, parity_error, stop_error, break_det, busy);
    modport slave  (input  p_data, data_valid, parity_error, stop_error, break_det, busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with per-frame latched prescale, data length, parity and stop configuration.
// Bits are majority-voted around mid-bit; all results are registered single-cycle pulses.
module uart_rx_cfg #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [3:0]         data_len,
    input  logic               par_en,
    input  logic [1:0]         par_typ,
    input  logic               stop2,
    uart_rx_cfg_if.master      rx_if
);
    localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(4);
    localparam logic [3:0]         L_MAX = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_rx_m, r_rx_s;
    logic [PRESC_W-1:0]  r_presc, r_edge_cnt;
    logic [3:0]          r_len, r_bit_cnt;
    logic                r_par_en, r_stop2;
    logic [1:0]          r_par_typ;
    logic [1:0]          r_samp;
    logic                r_bit, r_par_bit, r_par_err, r_stop_err, r_stop_one;
    logic [DATA_W-1:0]   r_shift, r_p_data;
    logic                r_dv, r_pe, r_se, r_brk, r_busy;

    logic [PRESC_W-1:0]  w_half, w_presc_cl;
    logic [3:0]          w_len_eff;
    logic                w_end, w_at_p1, w_maj, w_bit, w_last_data, w_last_stop;
    logic                w_par_exp, w_stop_fault, w_break, w_start, w_frame_end;

    assign w_presc_cl  = (prescale < P_MIN) ? P_MIN : prescale;
    assign w_len_eff   = (data_len == 4'd0 || data_len > L_MAX) ? L_MAX : data_len;
    assign w_half      = r_presc >> 1;
    assign w_end       = (r_edge_cnt == r_presc - PRESC_W'(1));
    assign w_at_p1     = (r_edge_cnt == w_half + PRESC_W'(1));
    assign w_maj       = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_s) | (r_samp[0] & r_rx_s);
    // With P=4 the third vote lands on the bit's last cycle, so use the live vote there.
    assign w_bit       = w_at_p1 ? w_maj : r_bit;
    assign w_last_data = (r_bit_cnt == r_len - 4'd1);
    assign w_last_stop = r_stop2 ? (r_bit_cnt == 4'd1) : 1'b1;
    assign w_stop_fault = r_stop_err | ~w_bit;
    assign w_break     = (r_shift == '0) && (!r_par_en || !r_par_bit) && !r_stop_one && !w_bit;

    always_comb begin
        w_par_exp = 1'b0;
        case (r_par_typ)
            2'b00:   w_par_exp = ^r_shift;
            2'b01:   w_par_exp = ~^r_shift;
            2'b10:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: if (!r_rx_s) begin
                w_state_nxt = S_START;
                w_start     = 1'b1;
            end
            S_START:  if (w_end) w_state_nxt = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_end && w_last_data) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_end) w_state_nxt = S_STOP;
            S_STOP: if (w_end && w_last_stop) begin
                w_frame_end = 1'b1;
                // A low line after a good stop bit is the next start bit, not a stuck line.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: if (r_rx_s) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx_in;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc    <= P_MIN;
            r_len      <= L_MAX;
            r_par_en   <= 1'b0;
            r_par_typ  <= 2'b00;
            r_stop2    <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_samp     <= 2'b11;
            r_bit      <= 1'b1;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop_one <= 1'b0;
        end else if (w_start) begin
            r_presc    <= w_presc_cl;
            r_len      <= w_len_eff;
            r_par_en   <= par_en;
            r_par_typ  <= par_typ;
            r_stop2    <= stop2;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop_one <= 1'b0;
        end else if (r_state == S_IDLE || r_state == S_WAIT_HI) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_edge_cnt <= w_end ? '0 : r_edge_cnt + PRESC_W'(1);
            if (w_end) r_bit_cnt <= (w_state_nxt != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
            if (r_edge_cnt == w_half - PRESC_W'(1)) r_samp[1] <= r_rx_s;
            if (r_edge_cnt == w_half)               r_samp[0] <= r_rx_s;
            if (w_at_p1)                            r_bit     <= w_maj;
            if (w_end && r_state == S_DATA) begin
                for (int unsigned i = 0; i < DATA_W; i++)
                    if (r_bit_cnt == 4'(i)) r_shift[i] <= w_bit;
            end
            if (w_end && r_state == S_PARITY) begin
                r_par_bit <= w_bit;
                r_par_err <= (w_bit != w_par_exp);
            end
            if (w_end && r_state == S_STOP) begin
                if (w_bit) r_stop_one <= 1'b1;
                else       r_stop_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_data <= '0;
            r_dv     <= 1'b0;
            r_pe     <= 1'b0;
            r_se     <= 1'b0;
            r_brk    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_dv   <= 1'b0;
            r_pe   <= 1'b0;
            r_se   <= 1'b0;
            r_brk  <= 1'b0;
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_frame_end) begin
                if (w_break) begin
                    r_brk <= 1'b1;
                    r_se  <= 1'b1;
                end else if (r_par_err || w_stop_fault) begin
                    r_pe <= r_par_err;
                    r_se <= w_stop_fault;
                end else begin
                    r_dv     <= 1'b1;
                    r_p_data <= r_shift;
                end
            end
        end
    end

    assign rx_if.p_data       = r_p_data;
    assign rx_if.data_valid   = r_dv;
    assign rx_if.parity_error = r_pe;
    assign rx_if.stop_error   = r_se;
    assign rx_if.break_det    = r_brk;
    assign rx_if.busy         = r_busy;
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 8, maximum data bits per frame; legal 5..9
  PRESC_W, 6, width of prescale input
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  asynchronous, active-low reset
  rx_in  in  1  serial line, idle high, asynchronous to clk
  prescale  in  PRESC_W  clk cycles per bit
  data_len  in  4  data bits per frame; 0 or >DATA_W means DATA_W
  par_en  in  1  parity bit present
  par_typ  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
  stop2  in  1  1 = two stop bits, 0 = one
  p_data  out  DATA_W  last good frame, LSB-first assembled, unused MSBs zero
  data_valid  out  1  one-cycle pulse: good frame on p_data
  parity_error  out  1  one-cycle pulse
  stop_error  out  1  one-cycle pulse
  break_det  out  1  one-cycle pulse
  busy  out  1  high in every state except IDLE

Function
REQ-003 rx_in SHALL pass through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
REQ-004 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HI.
REQ-005 IDLE: rx_s==0 -> START next cycle with edge_cnt=0, bit_cnt=0; prescale, data_len, par_en, par_typ, stop2 latched that cycle; changes to config inputs mid-frame SHALL be ignored.
REQ-006 Latched prescale < 4 SHALL be clamped to 4.
REQ-007 edge_cnt SHALL count 0..P-1 (P = latched prescale) per bit, wrapping to 0 and incrementing bit_cnt at P-1.
REQ-008 Each bit value SHALL be the majority of rx_s at edge_cnt = P/2-1, P/2, P/2+1 (integer divide).
REQ-009 START: sampled 1 -> glitch; return to IDLE at end of bit, no output pulse; sampled 0 -> DATA.
REQ-010 DATA: receive L bits (L = effective data_len) LSB first into shift register; then PARITY if par_en, else STOP.
REQ-011 PARITY: expected bit = XOR of data (even), its inverse (odd), 1 (mark), 0 (space); mismatch flags parity fault.
REQ-012 STOP: one or two stop bits per stop2; any stop bit sampled 0 flags stop fault.
REQ-013 Outputs SHALL pulse in the cycle after the last cycle (edge_cnt==P-1) of the final stop bit, simultaneously: data_valid=1 and p_data updated only if no fault; otherwise parity_error and/or stop_error=1 as applicable, data_valid=0, p_data unchanged.
REQ-014 Break: all data bits 0, parity bit (if present) 0, and all stop bits 0 -> break_det=1 with stop_error=1 in the same cycle; parity_error not asserted.
REQ-015 After frame end: rx_s==1 -> IDLE; rx_s==0 -> WAIT_HI, staying until rx_s==1, then IDLE; no new frame starts from WAIT_HI.
REQ-016 Back-to-back frames SHALL be accepted with zero idle bits beyond the stop bit(s).
REQ-017 Frame duration from START entry to output pulse SHALL be P*(1+L+par_en+1+stop2) cycles.
REQ-018 No output pulse SHALL last more than one cycle; all outputs SHALL be registered.

Reset
REQ-019 rst low SHALL asynchronously force IDLE, synchroniser flops to 1, counters to 0, p_data to 0, all pulse outputs and busy to 0.
REQ-020 rst asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh falling edge.

Verification
REQ-021 P=8, L=8, no parity, 1 stop, send 0xA5 -> one data_valid pulse, p_data=0xA5, exactly 80 cycles after START entry.
REQ-022 P=16, L=7, even parity, 2 stop, send 0x35 with parity bit 1 (wrong) -> parity_error pulse, data_valid 0, p_data holds previous value.
REQ-023 rx_in low 3 cycles then high, P=8 -> no pulse on any output, busy returns to 0 after 8 cycles.
REQ-024 P=8, L=8, rx_in low 200 cycles -> exactly one break_det+stop_error pulse, no further frames until rx_in high then low again.
REQ-025 P=16, back-to-back 0x00 then 0xFF, no idle gap -> two data_valid pulses 160 cycles apart, correct data each.
REQ-026 rst pulsed at DATA bit 3, then valid frame 0x3C -> only one data_valid, p_data=0x3C; prescale changed to 4 mid-frame -> frame still decoded at old rate.
